// File: rtl/monostable_multi_pkg.sv
// Shared types and default parameters for the multi-channel monostable.
// Holds the per-channel FSM state enum and default NUM_CH/CNT_W/HOLDOFF.
package monostable_multi_pkg;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_HOLDOFF = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } chan_state_e;

endpackage

// File: rtl/monostable_chan.sv
// One monostable channel: optional trigger sync, rising-edge detect,
// IDLE/ACTIVE/HOLD FSM and a non-wrapping down counter.
// Ports: clk, reset (async, active-high), trigger, width[CNT_W], retrig,
//        pulse (registered), done (one-cycle strobe at pulse fall).
// Macro MONOSTABLE_MULTI_SYNC_EN adds a 2-flop trigger synchroniser.
module monostable_chan
    import monostable_multi_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int HOLDOFF = DEF_HOLDOFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic [CNT_W-1:0] width,
    input  logic             retrig,
    output logic             pulse,
    output logic             done
);

    localparam logic [CNT_W-1:0] HOLD_LEN = CNT_W'(HOLDOFF);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic trig_s;

`ifdef MONOSTABLE_MULTI_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= trigger;
            sync2_q <= sync1_q;
        end
    end

    assign trig_s = sync2_q;
`else
    assign trig_s = trigger;
`endif

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q;
    logic             pulse_q, pulse_d;
    logic             done_q, done_d;
    logic             rise;
    logic             width_nz;

    assign rise     = trig_s & ~prev_q;
    assign width_nz = |width;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise && width_nz) begin
                    state_d = ACTIVE;
                    cnt_d   = width;
                end
            end
            ACTIVE: begin
                // A retrigger on the final cycle takes priority over the fall.
                if (rise && retrig && width_nz) begin
                    cnt_d = width;
                end else if (cnt_q > ONE) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    done_d = 1'b1;
                    if (HOLDOFF == 0) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LEN;
                    end
                end
            end
            HOLD: begin
                if (cnt_q > ONE) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        pulse_d = (state_d == ACTIVE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= trig_s;
            pulse_q <= pulse_d;
            done_q  <= done_d;
        end
    end

    assign pulse = pulse_q;
    assign done  = done_q;

endmodule

// File: rtl/monostable_multi.sv
// NUM_CH independent monostable pulse generators sharing clk/reset.
// Ports: clk, reset (async, active-high), trigger[NUM_CH],
//        width[NUM_CH*CNT_W] (ch i at [i*CNT_W +: CNT_W]), retrig[NUM_CH],
//        pulse[NUM_CH], done[NUM_CH].
// Macro MONOSTABLE_MULTI_SYNC_EN enables per-channel trigger synchronisers.
module monostable_multi
    import monostable_multi_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int HOLDOFF = DEF_HOLDOFF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       trigger,
    input  logic [NUM_CH*CNT_W-1:0] width,
    input  logic [NUM_CH-1:0]       retrig,
    output logic [NUM_CH-1:0]       pulse,
    output logic [NUM_CH-1:0]       done
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        monostable_chan #(
            .CNT_W   (CNT_W),
            .HOLDOFF (HOLDOFF)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .trigger (trigger[i]),
            .width   (width[i*CNT_W +: CNT_W]),
            .retrig  (retrig[i]),
            .pulse   (pulse[i]),
            .done    (done[i])
        );
    end

endmodule

// File: doc/monostable_multi.md
MONOSTABLE_MULTI -- requirements
Module: monostable_multi

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent pulse channels (1..32).
REQ-002 Parameter CNT_W, default 8, width of pulse-length and counter fields.
REQ-003 Parameter HOLDOFF, default 0, post-pulse cycles during which triggers are ignored (0..2^CNT_W-1).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 trigger  input  NUM_CH  per-channel trigger; rising edge starts a pulse.
REQ-007 width  input  NUM_CH*CNT_W  per-channel pulse length in clk cycles; channel i uses bits [i*CNT_W +: CNT_W].
REQ-008 retrig  input  NUM_CH  per-channel mode: 1 = retriggerable, 0 = one-shot.
REQ-009 pulse  output  NUM_CH  registered pulse outputs.
REQ-010 done  output  NUM_CH  registered one-cycle strobe on each pulse falling edge.

Function
REQ-011 Each channel SHALL run an independent FSM with states IDLE, ACTIVE, HOLD.
REQ-012 Edge detection SHALL compare the (optionally synchronised) trigger against its value registered on the previous clk edge; a rising edge is prev=0, cur=1.
REQ-013 On a rising edge detected in IDLE with width!=0, the channel SHALL latch width into its counter, enter ACTIVE, and assert pulse starting on the next clk edge.
REQ-014 pulse SHALL stay high for exactly the latched width cycles; changes to width during ACTIVE SHALL have no effect.
REQ-015 A rising edge with width==0 SHALL be ignored; no pulse, no done.
REQ-016 In ACTIVE with retrig=1, a rising edge SHALL reload the counter with the current width, extending pulse with no low gap; if current width==0 the edge is ignored.
REQ-017 In ACTIVE with retrig=0, rising edges SHALL be ignored.
REQ-018 On the last ACTIVE cycle, pulse SHALL deassert and done SHALL assert for exactly one cycle on the same clk edge.
REQ-019 A retrigger edge on the last ACTIVE cycle (retrig=1) SHALL win: counter reloads, pulse stays high, no done.
REQ-020 After ACTIVE, the channel SHALL enter HOLD for HOLDOFF cycles ignoring all edges, then IDLE; HOLDOFF=0 SHALL go straight to IDLE.
REQ-021 A held-high trigger SHALL NOT generate further pulses; a new 0->1 transition is required.
REQ-022 Counters SHALL never wrap; they decrement to zero and stop.
REQ-023 Channels SHALL NOT interact; simultaneous edges on all channels SHALL all be honoured.

Reset
REQ-024 While reset is high: all FSMs IDLE, counters 0, pulse=0, done=0, edge/sync registers 0.
REQ-025 Reset asserted mid-pulse SHALL clear pulse immediately (asynchronously) without a done strobe.
REQ-026 A trigger already high at reset release SHALL be seen as a rising edge (prev register resets to 0).

Configuration
REQ-027 Macro MONOSTABLE_MULTI_SYNC_EN defined: each trigger passes through a 2-flop synchroniser before edge detection; trigger-to-pulse latency = 3 clk edges.
REQ-028 Macro undefined: trigger is assumed synchronous to clk and fed straight to edge detection; trigger-to-pulse latency = 1 clk edge.

Structure
REQ-029 Package monostable_multi_pkg SHALL hold the FSM state enum (IDLE, ACTIVE, HOLD) and the default parameter constants.
REQ-030 One sub-module, monostable_chan, SHALL implement a single channel (sync, edge detect, FSM, counter), instantiated NUM_CH times via generate.

Verification (macro undefined unless stated)
REQ-031 Ch0 width=5, retrig=0, one rising edge -> pulse[0] high exactly 5 cycles starting 1 cycle after edge; done[0] high 1 cycle at fall.
REQ-032 Ch1 width=4, retrig=1, second edge 3 cycles after first -> pulse[1] continuous 7 cycles, single done; same stimulus with retrig=0 -> 4 cycles.
REQ-033 HOLDOFF=3, width=2: edge 1 cycle after pulse falls ignored; edge 4 cycles after fall -> new 2-cycle pulse.
REQ-034 width=0 edge -> no pulse, no done; width changed 5->9 mid-pulse -> pulse still 5 cycles.
REQ-035 Reset asserted 2 cycles into width=6 pulse -> pulse 0 immediately, no done; trigger held high across release -> one 6-cycle pulse.
REQ-036 MONOSTABLE_MULTI_SYNC_EN defined, all 4 channels triggered together with widths 1,2,3,4 -> pulses start 3 edges after trigger, lengths 1,2,3,4.
